program_sequencer: RTL

Synthesizable run controller that launches and supervises one or more processor instances, replacing hand-written per-processor stimulus. Each processor is launched in turn with a multi-cycle init pulse or a single-cycle restart pulse. The block waits for that processor's done, counts its run cycles, and enforces a timeout. It sits between the top-level harness or host control and the processor array, and reports per-program status and a job-complete pulse.

---
 rtl/program_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: launches each supervised processor in turn (cold via a
// multi-cycle proc_init pulse or warm via a one-cycle proc_restart pulse),
// waits for that processor's done, counts its run cycles, enforces a timeout,
// and reports per-program results plus a job-complete pulse.
module program_sequencer #(
  parameter int NUM_PROGS   = 2,
  parameter int SEL_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1000
) (
  input  logic                 clock,
  input  logic                 init_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 warm,
  input  logic [SEL_W-1:0]     prog_sel,
  input  logic [NUM_PROGS-1:0] proc_done,
  output logic [NUM_PROGS-1:0] proc_init,
  output logic [NUM_PROGS-1:0] proc_restart,
  output logic                 busy,
  output logic [SEL_W-1:0]     cur_prog,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic                 cycles_valid,
  output logic [NUM_PROGS-1:0] timeout_flags,
  output logic                 sel_err,
  output logic                 job_done
);

  // Launch-length counter only needs to reach INIT_CYCLES-1.
  localparam int                   LC_W      = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [LC_W-1:0]      LC_LAST   = LC_W'(INIT_CYCLES - 1);
  // One extra bit so NUM_PROGS itself is representable for range checks.
  localparam logic [SEL_W:0]       NP_C      = (SEL_W + 1)'(NUM_PROGS);
  localparam logic [SEL_W:0]       LAST_PROG = (SEL_W + 1)'(NUM_PROGS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  // TIMEOUT is expected to fit in CNT_WIDTH bits.
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam bit                   TO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    NEXT   = 2'd3
  } state_t;

  state_t               state_q;
  logic                 mode_q;
  logic                 warm_q;
  logic [LC_W-1:0]      lcnt_q;
  logic [CNT_WIDTH-1:0] run_cnt_q;
  logic [SEL_W-1:0]     cur_prog_q;
  logic [NUM_PROGS-1:0] proc_init_q;
  logic [NUM_PROGS-1:0] proc_restart_q;
  logic [CNT_WIDTH-1:0] cycles_q;
  logic                 cycles_valid_q;
  logic [NUM_PROGS-1:0] timeout_flags_q;
  logic                 sel_err_q;
  logic                 job_done_q;

  logic [CNT_WIDTH-1:0] run_cnt_d;
  logic [SEL_W-1:0]     launch_idx_d;
  logic                 done_cur;
  logic                 timeout_hit;
  logic                 sel_bad;
  logic                 more_progs;

  function automatic logic [NUM_PROGS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_PROGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (SEL_W'(i) == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Saturating run counter step, completion conditions and next launch target.
  always_comb begin
    run_cnt_d    = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
    done_cur     = proc_done[cur_prog_q];
    timeout_hit  = TO_EN && (run_cnt_d == TIMEOUT_C);
    sel_bad      = ({1'b0, prog_sel} >= NP_C);
    more_progs   = ({1'b0, cur_prog_q} < LAST_PROG);
    launch_idx_d = cur_prog_q + 1'b1;
    if (state_q == IDLE) begin
      launch_idx_d = mode ? '0 : prog_sel;
    end
  end

  // Run-control FSM; every output is a register so nothing glitches toward the processors.
  always_ff @(posedge clock or negedge init_n) begin
    if (!init_n) begin
      state_q         <= IDLE;
      mode_q          <= 1'b0;
      warm_q          <= 1'b0;
      lcnt_q          <= '0;
      run_cnt_q       <= '0;
      cur_prog_q      <= '0;
      proc_init_q     <= '0;
      proc_restart_q  <= '0;
      cycles_q        <= '0;
      cycles_valid_q  <= 1'b0;
      timeout_flags_q <= '0;
      sel_err_q       <= 1'b0;
      job_done_q      <= 1'b0;
    end else begin
      cycles_valid_q <= 1'b0;
      job_done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q          <= mode;
            warm_q          <= warm;
            timeout_flags_q <= '0;
            sel_err_q       <= 1'b0;
            if (!mode && sel_bad) begin
              // Nothing to run: report the bad selection and finish the job at once.
              sel_err_q  <= 1'b1;
              job_done_q <= 1'b1;
              cur_prog_q <= prog_sel;
            end else begin
              cur_prog_q <= launch_idx_d;
              lcnt_q     <= '0;
              run_cnt_q  <= '0;
              state_q    <= LAUNCH;
              if (warm) proc_restart_q <= onehot(launch_idx_d);
              else      proc_init_q    <= onehot(launch_idx_d);
            end
          end
        end

        LAUNCH: begin
          // proc_done is deliberately not looked at here: it may still be
          // high from the previous run of this processor.
          if (warm_q || (lcnt_q == LC_LAST)) begin
            proc_init_q    <= '0;
            proc_restart_q <= '0;
            run_cnt_q      <= '0;
            state_q        <= RUN;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end

        RUN: begin
          run_cnt_q <= run_cnt_d;
          if (done_cur) begin
            // Done has priority over a coincident timeout.
            cycles_q       <= run_cnt_d;
            cycles_valid_q <= 1'b1;
            state_q        <= NEXT;
          end else if (timeout_hit) begin
            timeout_flags_q[cur_prog_q] <= 1'b1;
            cycles_q                    <= TIMEOUT_C;
            cycles_valid_q              <= 1'b1;
            state_q                     <= NEXT;
          end
        end

        NEXT: begin
          if (mode_q && more_progs) begin
            cur_prog_q <= launch_idx_d;
            lcnt_q     <= '0;
            run_cnt_q  <= '0;
            state_q    <= LAUNCH;
            if (warm_q) proc_restart_q <= onehot(launch_idx_d);
            else        proc_init_q    <= onehot(launch_idx_d);
          end else begin
            job_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign proc_init     = proc_init_q;
  assign proc_restart  = proc_restart_q;
  assign busy          = (state_q != IDLE);
  assign cur_prog      = cur_prog_q;
  assign cycles        = cycles_q;
  assign cycles_valid  = cycles_valid_q;
  assign timeout_flags = timeout_flags_q;
  assign sel_err       = sel_err_q;
  assign job_done      = job_done_q;

endmodule
